// File: rtl/key_expansion_seq_if.sv
// Handshake bundle between the key source, the key scheduler and the round datapath.
// roundKey layout (roundKey_t): w0 in [127:96] down to w3 in [31:0]; decrypt exists only with KEYEXP_DECRYPT_ORDER_EN.
interface key_expansion_seq_if #(
   parameter int IDX_W = 4
);
   logic             keyValid;
   logic             keyReady;
   logic [127:0]     cipherKey;
   logic             rkValid;
   logic             rkReady;
   logic [127:0]     roundKey;
   logic [IDX_W-1:0] roundIdx;
   logic             lastKey;
`ifdef KEYEXP_DECRYPT_ORDER_EN
   logic             decrypt;

   modport master (
      output keyValid, cipherKey, decrypt, rkReady,
      input  keyReady, rkValid, roundKey, roundIdx, lastKey
   );
   modport slave (
      input  keyValid, cipherKey, decrypt, rkReady,
      output keyReady, rkValid, roundKey, roundIdx, lastKey
   );
`else
   modport master (
      output keyValid, cipherKey, rkReady,
      input  keyReady, rkValid, roundKey, roundIdx, lastKey
   );
   modport slave (
      input  keyValid, cipherKey, rkReady,
      output keyReady, rkValid, roundKey, roundIdx, lastKey
   );
`endif
endinterface

// File: rtl/key_expansion_seq.sv
// Sequential AES-128 key schedule: one round key per accepted transfer, round 0 valid one cycle after key accept.
// KEYEXP_DECRYPT_ORDER_EN adds a decrypt input and an 11-entry store so the schedule can be emitted 10 down to 0.
module key_expansion_seq #(
   parameter int NUM_ROUNDS = 10,
   parameter int IDX_W      = 4
) (
   input logic               clock,
   input logic               reset,
   key_expansion_seq_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);
   localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

`ifdef KEYEXP_DECRYPT_ORDER_EN
   typedef enum logic [1:0] {IDLE, EMIT, EXPAND} state_t;
`else
   typedef enum logic [0:0] {IDLE, EMIT} state_t;
`endif

   state_t           state;
   state_t           state_nxt;
   logic [127:0]     cur_key;
   logic [IDX_W-1:0] round;
   logic [127:0]     next_key;
   logic             reverse;
   logic             at_end;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [IDX_W-1:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] round_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] rot, t, w4, w5, w6, w7;
      rot = {k[23:0], k[31:24]};
      t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
      w4  = k[127:96] ^ t;
      w5  = k[95:64]  ^ w4;
      w6  = k[63:32]  ^ w5;
      w7  = k[31:0]   ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   assign next_key = round_step(cur_key, rcon(round + ONE));
   assign at_end   = reverse ? (round == '0) : (round == LAST_IDX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.keyValid) begin
`ifdef KEYEXP_DECRYPT_ORDER_EN
               state_nxt = bus.decrypt ? EXPAND : EMIT;
`else
               state_nxt = EMIT;
`endif
            end
         end
         EMIT:    if (bus.rkReady && at_end) state_nxt = IDLE;
`ifdef KEYEXP_DECRYPT_ORDER_EN
         EXPAND:  if (round == LAST_IDX) state_nxt = EMIT;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.keyReady = (state == IDLE);
      bus.rkValid  = (state == EMIT);
      bus.lastKey  = (state == EMIT) && at_end;
   end

   assign bus.roundKey = cur_key;
   assign bus.roundIdx = round;

`ifdef KEYEXP_DECRYPT_ORDER_EN
   logic [127:0] key_store [0:NUM_ROUNDS];

   // Store carries no reset: every entry is rewritten by EXPAND before it is read.
   always_ff @(posedge clock) begin
      if (state == EXPAND) key_store[round] <= cur_key;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_key <= '0;
         round   <= '0;
         reverse <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.keyValid) begin
                  cur_key <= bus.cipherKey;
                  round   <= '0;
                  reverse <= 1'b0;
               end
            end
            EMIT: begin
               if (bus.rkReady && !at_end) begin
                  if (reverse) begin
                     cur_key <= key_store[round - ONE];
                     round   <= round - ONE;
                  end else begin
                     cur_key <= next_key;
                     round   <= round + ONE;
                  end
               end
            end
            EXPAND: begin
               // cur_key already holds round 10 when the last entry is stored; emit starts from it.
               if (round == LAST_IDX) begin
                  reverse <= 1'b1;
               end else begin
                  cur_key <= next_key;
                  round   <= round + ONE;
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign reverse = 1'b0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur_key <= '0;
         round   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.keyValid) begin
                  cur_key <= bus.cipherKey;
                  round   <= '0;
               end
            end
            EMIT: begin
               if (bus.rkReady && !at_end) begin
                  cur_key <= next_key;
                  round   <= round + ONE;
               end
            end
            default: ;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: FIPS-197 word-level schedule model with an S-box derived from GF(2^8) inversion.
module tb_key_expansion_seq;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   key_expansion_seq_if #(.IDX_W(4)) bus ();

   key_expansion_seq #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   int tests    = 0;
   int failures = 0;

   logic [7:0]   sbox_ref [0:255];
   logic [127:0] sched    [0:10];
   logic [127:0] got_keys [0:10];

   typedef struct {
      logic [127:0] key;
      int           idx;
      logic [127:0] rk;
   } vec_t;

   vec_t vecs [0:5];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
         sbox_ref[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic compute_sched(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
   task automatic apply_key(input logic [127:0] key);
      chk("keyReady_before_key", 128'(bus.keyReady), 128'(1));
      bus.keyValid  = 1'b1;
      bus.cipherKey = key;
      @(negedge clock);
      bus.keyValid  = 1'b0;
      bus.cipherKey = 'x;
   endtask

   task automatic emit_check(input int from);
      bus.rkReady = 1'b1;
      for (int r = from; r <= 10; r++) begin
         chk($sformatf("rkValid_r%0d", r), 128'(bus.rkValid), 128'(1));
         chk($sformatf("roundIdx_r%0d", r), 128'(bus.roundIdx), 128'(r));
         chk($sformatf("roundKey_r%0d", r), bus.roundKey, sched[r]);
         chk($sformatf("lastKey_r%0d", r), 128'(bus.lastKey), 128'(r == 10));
         got_keys[r] = bus.roundKey;
         @(negedge clock);
      end
      chk("keyReady_after_last", 128'(bus.keyReady), 128'(1));
      chk("rkValid_after_last", 128'(bus.rkValid), 128'(0));
   endtask

   task automatic run_full(input logic [127:0] key);
      compute_sched(key);
      apply_key(key);
      emit_check(0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] rkey;
      int           exp_idx;
      int           cycles;
      bit           done;

      vecs[0] = '{KEY_A, 0,  KEY_A};
      vecs[1] = '{KEY_A, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[2] = '{KEY_A, 2,  128'hf2c295f27a96b9435935807a7359f67f};
      vecs[3] = '{KEY_A, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[4] = '{128'h0, 1,  128'h62636363626363636263636362636363};
      vecs[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      reset         = 1'b1;
      bus.keyValid  = 1'b0;
      bus.cipherKey = '0;
      bus.rkReady   = 1'b0;
`ifdef KEYEXP_DECRYPT_ORDER_EN
      bus.decrypt   = 1'b0;
`endif
      build_sbox();

      @(negedge clock);
      chk("reset_keyReady", 128'(bus.keyReady), 128'(1));
      chk("reset_rkValid", 128'(bus.rkValid), 128'(0));
      chk("reset_roundKey", bus.roundKey, 128'(0));
      chk("reset_roundIdx", 128'(bus.roundIdx), 128'(0));
      chk("reset_lastKey", 128'(bus.lastKey), 128'(0));
      reset = 1'b0;
      @(negedge clock);

      // Known-answer vectors, each run back-to-back at the minimum key period.
      for (int i = 0; i < 6; i++) begin
         run_full(vecs[i].key);
         chk($sformatf("vector%0d_idx%0d", i, vecs[i].idx), got_keys[vecs[i].idx], vecs[i].rk);
      end

      // Backpressure held at round 2.
      compute_sched(KEY_A);
      apply_key(KEY_A);
      bus.rkReady = 1'b1;
      @(negedge clock);
      @(negedge clock);
      bus.rkReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("stall_roundIdx", 128'(bus.roundIdx), 128'(2));
         chk("stall_roundKey", bus.roundKey, 128'hf2c295f27a96b9435935807a7359f67f);
         chk("stall_lastKey", 128'(bus.lastKey), 128'(0));
         @(negedge clock);
      end
      emit_check(2);

      // New key offered throughout EMIT is ignored, then accepted right after the last transfer.
      compute_sched(KEY_A);
      apply_key(KEY_A);
      bus.rkReady = 1'b1;
      for (int r = 0; r <= 10; r++) begin
         bus.keyValid  = 1'b1;
         bus.cipherKey = '0;
         chk("ignored_keyReady", 128'(bus.keyReady), 128'(0));
         chk($sformatf("ignored_roundKey_r%0d", r), bus.roundKey, sched[r]);
         chk($sformatf("ignored_roundIdx_r%0d", r), 128'(bus.roundIdx), 128'(r));
         @(negedge clock);
      end
      chk("ignored_then_ready", 128'(bus.keyReady), 128'(1));
      @(negedge clock);
      bus.keyValid = 1'b0;
      compute_sched(128'h0);
      emit_check(0);

      // Asynchronous reset while round 5 is on the output.
      compute_sched(KEY_A);
      apply_key(KEY_A);
      bus.rkReady = 1'b1;
      repeat (5) @(negedge clock);
      chk("pre_reset_roundIdx", 128'(bus.roundIdx), 128'(5));
      #2 reset = 1'b1;
      #1;
      chk("async_rst_rkValid", 128'(bus.rkValid), 128'(0));
      chk("async_rst_keyReady", 128'(bus.keyReady), 128'(1));
      chk("async_rst_roundIdx", 128'(bus.roundIdx), 128'(0));
      chk("async_rst_roundKey", bus.roundKey, 128'(0));
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      run_full({$urandom, $urandom, $urandom, $urandom});

      // Random keys with random consumer stalls and junk key offers during EMIT.
      for (int n = 0; n < 15; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         compute_sched(rkey);
         apply_key(rkey);
         exp_idx = 0;
         cycles  = 0;
         done    = 1'b0;
         while (!done && cycles < 200) begin
            chk("rand_rkValid", 128'(bus.rkValid), 128'(1));
            chk("rand_keyReady", 128'(bus.keyReady), 128'(0));
            chk($sformatf("rand_roundIdx_k%0d", n), 128'(bus.roundIdx), 128'(exp_idx));
            chk($sformatf("rand_roundKey_k%0d_r%0d", n, exp_idx), bus.roundKey, sched[exp_idx]);
            chk("rand_lastKey", 128'(bus.lastKey), 128'(exp_idx == 10));
            bus.rkReady   = 1'($urandom_range(0, 1));
            bus.keyValid  = 1'($urandom_range(0, 1));
            bus.cipherKey = {$urandom, $urandom, $urandom, $urandom};
            if (bus.rkReady) begin
               if (exp_idx == 10) done = 1'b1;
               else exp_idx++;
            end
            @(negedge clock);
            cycles++;
         end
         bus.keyValid = 1'b0;
         if (!done) begin
            tests++;
            failures++;
            $display("FAIL rand_timeout_k%0d: stuck at roundIdx %0d, expected completion within 200 cycles", n, exp_idx);
         end
         chk("rand_idle_rkValid", 128'(bus.rkValid), 128'(0));
      end

`ifdef KEYEXP_DECRYPT_ORDER_EN
      compute_sched(KEY_A);
      bus.decrypt = 1'b1;
      apply_key(KEY_A);
      bus.decrypt = 1'b0;
      bus.rkReady = 1'b1;
      for (int k = 0; k < 11; k++) begin
         chk("expand_rkValid", 128'(bus.rkValid), 128'(0));
         @(negedge clock);
      end
      for (int r = 10; r >= 0; r--) begin
         chk($sformatf("rev_rkValid_r%0d", r), 128'(bus.rkValid), 128'(1));
         chk($sformatf("rev_roundIdx_r%0d", r), 128'(bus.roundIdx), 128'(r));
         chk($sformatf("rev_roundKey_r%0d", r), bus.roundKey, sched[r]);
         chk($sformatf("rev_lastKey_r%0d", r), 128'(bus.lastKey), 128'(r == 0));
         @(negedge clock);
      end
      chk("rev_keyReady_after", 128'(bus.keyReady), 128'(1));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
